// File: rtl/intc_n.sv
// Vectored interrupt controller: rising-edge sources, mask/pend/swset registers,
// IRQ/ADDR request with IACK/EOI handshake. Define INTC_ROUND_ROBIN_EN for rotating priority.
module intc_n #(
    parameter int          NUM_IRQ   = 4,
    parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
    parameter int          VEC_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] src,
    input  logic [1:0]         A,
    input  logic               WE,
    input  logic [31:0]        WD,
    output logic [31:0]        RD,
    output logic               IRQ,
    input  logic               IACK,
    output logic [31:0]        ADDR
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] INSVC = 2'd2;

    logic [1:0]         state;
    logic [4:0]         id;
    logic [4:0]         sel;
    logic [NUM_IRQ-1:0] src_q, mask, pend, req, rise, id_oh;
    logic [NUM_IRQ-1:0] w1c, swset, ack_clr;
    logic               ack, eoi, req_id;
    logic [31:0]        mask_w, pend_w, src_w;

    assign rise  = src & ~src_q;
    assign req   = pend & mask;
    assign ack   = (state == REQ) && IACK;
    assign eoi   = WE && (A == 2'd2) && (state == INSVC);
    assign w1c   = (WE && A == 2'd1) ? WD[NUM_IRQ-1:0] : '0;
    assign swset = (WE && A == 2'd3) ? WD[NUM_IRQ-1:0] : '0;

    always_comb begin
        id_oh = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            id_oh[i] = (5'(i) == id);
    end

    assign ack_clr = ack ? id_oh : '0;
    assign req_id  = |(req & id_oh);

    generate
        if (NUM_IRQ < 32) begin : g_pad
            logic unused_wd;
            assign unused_wd = ^WD[31:NUM_IRQ];
        end
    endgenerate

`ifdef INTC_ROUND_ROBIN_EN
    logic [4:0] ptr;
    int         idx;
    logic       found;

    // Search starts one past the last acknowledged source and wraps.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            idx = int'(ptr) + 1 + k;
            if (idx >= NUM_IRQ) idx = idx - NUM_IRQ;
            if (idx >= NUM_IRQ) idx = idx - NUM_IRQ;
            for (int j = 0; j < NUM_IRQ; j++) begin
                if (!found && j == idx && req[j]) begin
                    sel   = 5'(j);
                    found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     ptr <= 5'(NUM_IRQ - 1);
        else if (ack) ptr <= id;
    end
`else
    always_comb begin
        sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (req[i]) sel = 5'(i);
    end
`endif

    // Sets beat clears, so a re-fire during W1C or IACK is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q <= '0;
            mask  <= '0;
            pend  <= '0;
        end else begin
            src_q <= src;
            if (WE && A == 2'd0) mask <= WD[NUM_IRQ-1:0];
            pend <= (pend & ~w1c & ~ack_clr) | rise | swset;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            id    <= '0;
            IRQ   <= 1'b0;
            ADDR  <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    id    <= sel;
                    ADDR  <= VEC_BASE + (32'(sel) << VEC_SHIFT);
                    IRQ   <= 1'b1;
                    state <= REQ;
                end
                REQ: if (IACK) begin
                    IRQ   <= 1'b0;
                    state <= INSVC;
                end else if (!req_id) begin
                    IRQ   <= 1'b0;
                    state <= IDLE;
                end
                INSVC: if (eoi) state <= IDLE;
                default: begin
                    IRQ   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mask_w = '0;
        pend_w = '0;
        src_w  = '0;
        mask_w[NUM_IRQ-1:0] = mask;
        pend_w[NUM_IRQ-1:0] = pend;
        src_w[NUM_IRQ-1:0]  = src;
        case (A)
            2'd0:    RD = mask_w;
            2'd1:    RD = pend_w;
            2'd2:    RD = {22'b0, state, 3'b0, id};
            default: RD = src_w;
        endcase
    end
endmodule

// File: tb/tb_intc_n.sv
// Directed vector bench for intc_n: table of per-cycle stimulus plus hand sequences.
module tb_intc_n;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  src = '0;
    logic [1:0]  A = '0;
    logic        WE = 1'b0;
    logic [31:0] WD = '0;
    logic [31:0] RD;
    logic        IRQ;
    logic        IACK = 1'b0;
    logic [31:0] ADDR;

    int n_chk = 0;
    int n_pass = 0;

    intc_n dut (.clk(clk), .rst(rst), .src(src), .A(A), .WE(WE), .WD(WD),
                .RD(RD), .IRQ(IRQ), .IACK(IACK), .ADDR(ADDR));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  src;
        logic        we;
        logic [1:0]  a;
        logic [31:0] wd;
        logic        iack;
        logic [1:0]  ca;
        logic [31:0] erd;
        logic        eirq;
        logic        chk_addr;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [3:0] s, logic we, logic [1:0] a, logic [31:0] wd,
                                logic ia, logic [1:0] ca, logic [31:0] erd, logic eirq,
                                logic ca_en, logic [31:0] eaddr);
        vec_t v;
        v.src = s; v.we = we; v.a = a; v.wd = wd; v.iack = ia;
        v.ca = ca; v.erd = erd; v.eirq = eirq; v.chk_addr = ca_en; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        A = a;
        #1;
        chk(name, RD, exp);
    endtask

    initial begin
        // Each vector: drive, one edge, then read register ca and check IRQ/ADDR.
        // Basic flow on src[2]
        vt.push_back(mk(4'h0, 1, 2'd0, 32'hF, 0, 2'd0, 32'hF,   0, 0, 0));       // 0 MASK=F
        vt.push_back(mk(4'h4, 0, 2'd0, 0,     0, 2'd1, 32'h4,   0, 0, 0));       // 1 PEND at k
        vt.push_back(mk(4'h4, 0, 2'd0, 0,     0, 2'd2, 32'h102, 1, 1, 32'h120)); // 2 IRQ at k+1
        vt.push_back(mk(4'h0, 0, 2'd0, 0,     1, 2'd1, 32'h0,   0, 0, 0));       // 3 IACK
        vt.push_back(mk(4'h0, 0, 2'd0, 0,     0, 2'd2, 32'h202, 0, 0, 0));       // 4 INSVC
        vt.push_back(mk(4'h0, 1, 2'd2, 0,     0, 2'd2, 32'h002, 0, 0, 0));       // 5 EOI
        // src[1] and src[3] together
        vt.push_back(mk(4'hA, 0, 2'd0, 0,     0, 2'd1, 32'hA,   0, 0, 0));       // 6
        vt.push_back(mk(4'hA, 0, 2'd0, 0,     0, 2'd2, 32'h101, 1, 1, 32'h110)); // 7
        vt.push_back(mk(4'hA, 0, 2'd0, 0,     1, 2'd1, 32'h8,   0, 0, 0));       // 8
        vt.push_back(mk(4'hA, 1, 2'd2, 0,     0, 2'd2, 32'h001, 0, 0, 0));       // 9 EOI
        vt.push_back(mk(4'hA, 0, 2'd0, 0,     0, 2'd2, 32'h103, 1, 1, 32'h130)); // 10
        vt.push_back(mk(4'h0, 0, 2'd0, 0,     1, 2'd1, 32'h0,   0, 0, 0));       // 11
        vt.push_back(mk(4'h0, 1, 2'd2, 0,     0, 2'd2, 32'h003, 0, 0, 0));       // 12
        // Masked source, then unmask
        vt.push_back(mk(4'h0, 1, 2'd0, 32'h0, 0, 2'd0, 32'h0,   0, 0, 0));       // 13
        vt.push_back(mk(4'h1, 0, 2'd0, 0,     0, 2'd1, 32'h1,   0, 0, 0));       // 14
        vt.push_back(mk(4'h0, 0, 2'd0, 0,     0, 2'd1, 32'h1,   0, 0, 0));       // 15
        vt.push_back(mk(4'h0, 1, 2'd0, 32'h1, 0, 2'd0, 32'h1,   0, 0, 0));       // 16 MASK=1
        vt.push_back(mk(4'h0, 0, 2'd0, 0,     0, 2'd2, 32'h100, 1, 1, 32'h100)); // 17
        vt.push_back(mk(4'h0, 0, 2'd0, 0,     1, 2'd1, 32'h0,   0, 0, 0));       // 18
        vt.push_back(mk(4'h0, 1, 2'd2, 0,     0, 2'd2, 32'h000, 0, 0, 0));       // 19
        // Withdrawal of id 2 by W1C
        vt.push_back(mk(4'h0, 1, 2'd0, 32'hF, 0, 2'd0, 32'hF,   0, 0, 0));       // 20
        vt.push_back(mk(4'h4, 0, 2'd0, 0,     0, 2'd1, 32'h4,   0, 0, 0));       // 21
        vt.push_back(mk(4'h4, 0, 2'd0, 0,     0, 2'd2, 32'h102, 1, 1, 32'h120)); // 22
        vt.push_back(mk(4'h0, 1, 2'd1, 32'h4, 0, 2'd1, 32'h0,   1, 1, 32'h120)); // 23 W1C
        vt.push_back(mk(4'h0, 0, 2'd0, 0,     0, 2'd2, 32'h002, 0, 0, 0));       // 24 IDLE
        vt.push_back(mk(4'h0, 0, 2'd0, 0,     1, 2'd2, 32'h002, 0, 0, 0));       // 25 IACK idle
        // Conflicts
        vt.push_back(mk(4'h0, 1, 2'd0, 32'h0, 0, 2'd0, 32'h0,   0, 0, 0));       // 26
        vt.push_back(mk(4'h1, 0, 2'd0, 0,     0, 2'd1, 32'h1,   0, 0, 0));       // 27
        vt.push_back(mk(4'h0, 0, 2'd0, 0,     0, 2'd1, 32'h1,   0, 0, 0));       // 28
        vt.push_back(mk(4'h1, 1, 2'd1, 32'h1, 0, 2'd1, 32'h1,   0, 0, 0));       // 29 rise+W1C
        vt.push_back(mk(4'h1, 1, 2'd1, 32'h1, 0, 2'd1, 32'h0,   0, 0, 0));       // 30 W1C alone
        vt.push_back(mk(4'h1, 0, 2'd0, 0,     0, 2'd3, 32'h1,   0, 0, 0));       // 31 raw src
        vt.push_back(mk(4'h0, 1, 2'd3, 32'h8, 0, 2'd1, 32'h8,   0, 0, 0));       // 32 SWSET
        vt.push_back(mk(4'h0, 1, 2'd0, 32'hF, 0, 2'd0, 32'hF,   0, 0, 0));       // 33
        vt.push_back(mk(4'h0, 0, 2'd0, 0,     0, 2'd2, 32'h103, 1, 1, 32'h130)); // 34

        // Reset state
        #1;
        chk("rst_irq", {31'b0, IRQ}, 32'h0);
        chk("rst_addr", ADDR, 32'h0);
        rd_chk("rst_mask", 2'd0, 32'h0);
        rd_chk("rst_pend", 2'd1, 32'h0);
        rd_chk("rst_status", 2'd2, 32'h0);
        tick();
        rst = 1'b1;
        tick();

        foreach (vt[i]) begin
            src = vt[i].src; WE = vt[i].we; A = vt[i].a; WD = vt[i].wd; IACK = vt[i].iack;
            tick();
            WE = 1'b0; IACK = 1'b0;
            rd_chk($sformatf("v%0d_rd", i), vt[i].ca, vt[i].erd);
            chk($sformatf("v%0d_irq", i), {31'b0, IRQ}, {31'b0, vt[i].eirq});
            if (vt[i].chk_addr) chk($sformatf("v%0d_addr", i), ADDR, vt[i].eaddr);
        end

        // Ack id 3, then fire 1 and 3 in service: 1 is served next.
        IACK = 1'b1; tick(); IACK = 1'b0;
        chk("h_ack3_irq", {31'b0, IRQ}, 32'h0);
        rd_chk("h_ack3_status", 2'd2, 32'h203);
        src = 4'hA; tick();
        chk("h_insvc_irq", {31'b0, IRQ}, 32'h0);
        rd_chk("h_insvc_pend", 2'd1, 32'hA);
        WE = 1'b1; A = 2'd2; WD = '0; tick(); WE = 1'b0;
        rd_chk("h_eoi_status", 2'd2, 32'h003);
        chk("h_eoi_irq", {31'b0, IRQ}, 32'h0);
        tick();
        chk("h_next_irq", {31'b0, IRQ}, 32'h1);
        chk("h_next_addr", ADDR, 32'h110);
        IACK = 1'b1; tick(); IACK = 1'b0;
        rd_chk("h_ack1_pend", 2'd1, 32'h8);

        // Asynchronous reset while in service with pending bits
        rst = 1'b0;
        #1;
        chk("ar_irq", {31'b0, IRQ}, 32'h0);
        chk("ar_addr", ADDR, 32'h0);
        rd_chk("ar_pend", 2'd1, 32'h0);
        rd_chk("ar_mask", 2'd0, 32'h0);
        rd_chk("ar_status", 2'd2, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
